tristate_bus_arbiter: RTL and testbench

Round-robin arbiter that shares one tristate output bus among `NUM_REQ` driver blocks. Each driver puts its value on the bus only while its `grant` bit is high. The arbiter guarantees at most one grant at a time and inserts a break-before-make dead time between owners. It replaces the free-running `active` toggle at the top level with demand-driven, contention-free bus ownership.

---
 rtl/tristate_bus_pkg.sv | 13 +
 rtl/tristate_bus_arbiter_if.sv | 17 +
 rtl/rr_pick.sv | 25 ++
 rtl/tristate_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_tristate_bus_arbiter.sv | 138 +++++++++++++
 5 files changed

// File: rtl/tristate_bus_pkg.sv
// Shared types and defaults for the tristate bus arbiter.
package tristate_bus_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_REQ     = 2;
  localparam int DEF_SLOT_CYCLES = 32;
  localparam int DEF_TURNAROUND  = 1;
  localparam int BUS_WIDTH       = 8;
endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Request/grant bundle between the arbiter (master) and its bus drivers (slave).
interface tristate_bus_arbiter_if
  import tristate_bus_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
);
  localparam int OWN_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [OWN_W-1:0]   owner;
  logic               busy;
  logic               preempt;

  modport master (input req, output grant, owner, busy, preempt);
  modport slave  (output req, input grant, owner, busy, preempt);
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit after 'last', wrapping.
module rr_pick
  import tristate_bus_pkg::*;
#(
  parameter int  NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);
  int idx;

  // Scan farthest-first so the nearest candidate after 'last' overwrites the rest.
  always_comb begin
    winner = '0;
    valid  = |req;
    idx    = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last) + i) % NUM_REQ;
      if (req[IDX_W'(idx)]) winner = IDX_W'(idx);
    end
  end
endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin, break-before-make owner arbiter for a shared tristate bus.
// Define TRISTATE_BUS_ARB_TIMEOUT_EN to limit tenure to SLOT_CYCLES and emit preempt.
//
// state    | meaning
// ST_IDLE  | no owner; arbitrate every cycle
// ST_GRANT | one grant high; tenure counting
// ST_TURN  | all grants low for TURNAROUND cycles; arbitrate on the last one
module tristate_bus_arbiter
  import tristate_bus_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int SLOT_CYCLES = DEF_SLOT_CYCLES,
  parameter int TURNAROUND  = DEF_TURNAROUND
) (
  input  logic                    clk,
  input  logic                    reset,
  tristate_bus_arbiter_if.master  bus
);
  localparam int OWN_W  = $clog2(NUM_REQ);
  localparam int TEN_W  = $clog2(SLOT_CYCLES + 1);
  localparam int TURN_W = $clog2(TURNAROUND + 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [OWN_W-1:0]   last_q, last_d;
  logic [TEN_W-1:0]   tenure_q, tenure_d;
  logic [TURN_W-1:0]  turn_q, turn_d;
  logic               busy_q, busy_d;
  logic [OWN_W-1:0]   pick_winner;
  logic               pick_valid;
  logic               timeout;
  logic               arbitrate;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (bus.req),
    .last   (last_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

`ifdef TRISTATE_BUS_ARB_TIMEOUT_EN
  logic preempt_q, preempt_d;
  assign timeout = (tenure_q == TEN_W'(SLOT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    last_d    = last_q;
    tenure_d  = tenure_q;
    turn_d    = turn_q;
    arbitrate = 1'b0;
`ifdef TRISTATE_BUS_ARB_TIMEOUT_EN
    preempt_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: arbitrate = 1'b1;
      ST_GRANT: begin
        if (!bus.req[owner_q] || timeout) begin
          grant_d = '0;
          state_d = ST_TURN;
          turn_d  = TURN_W'(1);
`ifdef TRISTATE_BUS_ARB_TIMEOUT_EN
          // A simultaneous release wins over the timeout.
          preempt_d = bus.req[owner_q];
`endif
        end else if (tenure_q != '1) begin
          tenure_d = tenure_q + 1'b1;
        end
      end
      ST_TURN: begin
        if (turn_q == TURN_W'(TURNAROUND)) arbitrate = 1'b1;
        else turn_d = turn_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (arbitrate) begin
      if (pick_valid) begin
        grant_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_winner;
        owner_d  = pick_winner;
        last_d   = pick_winner;
        tenure_d = TEN_W'(1);
        state_d  = ST_GRANT;
      end else begin
        state_d = ST_IDLE;
      end
    end
    busy_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      last_q    <= OWN_W'(NUM_REQ - 1);
      tenure_q  <= '0;
      turn_q    <= '0;
      busy_q    <= 1'b0;
`ifdef TRISTATE_BUS_ARB_TIMEOUT_EN
      preempt_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      tenure_q  <= tenure_d;
      turn_q    <= turn_d;
      busy_q    <= busy_d;
`ifdef TRISTATE_BUS_ARB_TIMEOUT_EN
      preempt_q <= preempt_d;
`endif
    end
  end

  assign bus.grant = grant_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;
`ifdef TRISTATE_BUS_ARB_TIMEOUT_EN
  assign bus.preempt = preempt_q;
`else
  assign bus.preempt = 1'b0;
`endif
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter (NUM_REQ=4, TURNAROUND=1; SLOT_CYCLES=4 when timeout is built in).
module tb_tristate_bus_arbiter;
  localparam int NR = 4;
  localparam int TA = 1;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  tristate_bus_arbiter_if #(.NUM_REQ(NR)) bus_if ();

  tristate_bus_arbiter #(
    .NUM_REQ     (NR),
    .SLOT_CYCLES (SC),
    .TURNAROUND  (TA)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_out(input string tag, input logic [3:0] g, input logic [1:0] own,
                         input logic pre);
    chk({tag, ".grant"},   bus_if.grant,   g);
    chk({tag, ".owner"},   bus_if.owner,   own);
    chk({tag, ".busy"},    bus_if.busy,    g != 4'b0);
    chk({tag, ".preempt"}, bus_if.preempt, pre);
  endtask

  // Bus-safety properties on every cycle of every scenario.
  logic [3:0] prev_grant = 4'b0;
  int         zero_cnt   = 0;
  bit         seen_grant = 1'b0;
  always @(negedge clk) begin
    chk("onehot0", $onehot0(bus_if.grant), 1);
    if (bus_if.grant != 4'b0 && prev_grant != 4'b0)
      chk("no_overlap", bus_if.grant, prev_grant);
    if (bus_if.grant != 4'b0 && prev_grant == 4'b0 && seen_grant)
      chk("dead_time", zero_cnt >= TA, 1);
    if (bus_if.grant == 4'b0) zero_cnt++;
    else begin
      zero_cnt   = 0;
      seen_grant = 1'b1;
    end
    prev_grant = bus_if.grant;
  end

  initial begin
    reset = 1'b1;
    bus_if.req = 4'b1111;
    tick(); exp_out("rst_c1", 4'b0000, 2'd0, 1'b0);
    tick(); exp_out("rst_c2", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;
    tick(); exp_out("first_win", 4'b0001, 2'd0, 1'b0);

    bus_if.req = 4'b1110;
    tick(); exp_out("rel0_dead", 4'b0000, 2'd0, 1'b0);
    tick(); exp_out("rr_to1", 4'b0010, 2'd1, 1'b0);
    bus_if.req = 4'b1100;
    tick(); exp_out("rel1_dead", 4'b0000, 2'd1, 1'b0);
    tick(); exp_out("rr_to2", 4'b0100, 2'd2, 1'b0);

    bus_if.req = 4'b1111;
    reset = 1'b1;
    tick(); exp_out("midgrant_rst", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;
    tick(); exp_out("post_rst_win", 4'b0001, 2'd0, 1'b0);

    bus_if.req = 4'b0000;
    tick(); exp_out("drop_all", 4'b0000, 2'd0, 1'b0);
    tick(); exp_out("turn_to_idle", 4'b0000, 2'd0, 1'b0);
    tick(); exp_out("idle_hold", 4'b0000, 2'd0, 1'b0);
    bus_if.req = 4'b0001;
    tick(); exp_out("idle_lat1", 4'b0001, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); exp_out("hold0", 4'b0001, 2'd0, 1'b0);
    end
    bus_if.req = 4'b0000;
    tick(); exp_out("rel_lat1", 4'b0000, 2'd0, 1'b0);
    bus_if.req = 4'b0100;
    tick(); exp_out("gap_exact", 4'b0100, 2'd2, 1'b0);

    bus_if.req = 4'b1011;
    tick(); exp_out("rel2_dead", 4'b0000, 2'd2, 1'b0);
    tick(); exp_out("rr_to3", 4'b1000, 2'd3, 1'b0);
    bus_if.req = 4'b0011;
    tick(); exp_out("rel3_dead", 4'b0000, 2'd3, 1'b0);
    tick(); exp_out("rr_wrap0", 4'b0001, 2'd0, 1'b0);

`ifdef TRISTATE_BUS_ARB_TIMEOUT_EN
    reset = 1'b1;
    bus_if.req = 4'b1111;
    tick(); exp_out("to_rst", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < SC; k++) begin
        tick(); exp_out("to_slot", 4'(1 << (g % 4)), 2'(g % 4), 1'b0);
      end
      if (g < 4) begin
        tick(); exp_out("to_preempt", 4'b0000, 2'(g % 4), 1'b1);
      end
    end
    // Owner 0 is at its last tenure cycle and releases on the same edge.
    bus_if.req = 4'b0010;
    tick(); exp_out("rel_beats_to", 4'b0000, 2'd0, 1'b0);
    tick(); exp_out("solo_grant", 4'b0010, 2'd1, 1'b0);
    for (int k = 1; k < SC; k++) begin
      tick(); exp_out("solo_hold", 4'b0010, 2'd1, 1'b0);
    end
    tick(); exp_out("solo_preempt", 4'b0000, 2'd1, 1'b1);
    tick(); exp_out("solo_regrant", 4'b0010, 2'd1, 1'b0);
`else
    for (int i = 0; i < 100; i++) begin
      tick(); exp_out("no_timeout", 4'b0001, 2'd0, 1'b0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
